cpu_memory: RTL and testbench
=============================

# cpu_memory

Unified program/data memory that answers the CPU's memory port (`mem_addr`/`mem_we`/`mem_data` in, `mem_in` out) and owns boot sequencing. After reset it zeroes every word and accepts a program image over a valid/ready load port starting at address `LOAD_BASE`. It then releases the CPU from reset and serves its reads and writes. It sits between the board-level loader (UART/ROM streamer) and the `cpu` block.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: address width; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 16: word width.
- `LOAD_BASE`, 8: first address written by the load port; matches CPU start PC.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `mem_addr`  in  ADDR_WIDTH  CPU address.
- `mem_we`  in  1  CPU write enable.
- `mem_data`  in  DATA_WIDTH  CPU write data.
- `mem_in`  out  DATA_WIDTH  registered read data to CPU.
- `load_valid`  in  1  load word valid.
- `load_data`  in  DATA_WIDTH  load word.
- `load_last`  in  1  marks final load word; sampled with `load_valid`.
- `load_ready`  out  1  block accepts a load word this cycle.
- `cpu_rst_n`  out  1  active-low reset driven to the CPU.
- `load_ovf`  out  1  sticky: image reached top of memory without `load_last`.
- `load_count`  out  ADDR_WIDTH+1  number of words accepted in the current load.

## Operation
- FSM states: CLEAR, LOAD, RUN.
- Reset values: state CLEAR, clear pointer 0, load pointer `LOAD_BASE`, `mem_in` 0, `load_ready` 0, `cpu_rst_n` 0, `load_ovf` 0, `load_count` 0. Memory array is not reset; CLEAR zeroes it.
- CLEAR:
  - Each cycle writes 0 to mem[clear pointer], then increments the pointer.
  - After writing address 2^ADDR_WIDTH-1, goes to LOAD.
  - CPU port is ignored, and load port is not ready.
- LOAD:
  - `load_ready`=1.
  - On `load_valid`&&`load_ready`: mem[load pointer] <= `load_data`; pointer+1; `load_count`+1.
  - If `load_last`=1 on the accepted word, go to RUN.
  - If the accepted word was written at address 2^ADDR_WIDTH-1 without `load_last`, set `load_ovf` and go to RUN. No wrap: the pointer never returns to 0.
  - CPU port is ignored.
- RUN:
  - `load_ready`=0, and load port input is ignored.
  - `cpu_rst_n`=1 from the cycle after entering RUN.
  - Every cycle: `mem_in` <= mem[`mem_addr`]. If `mem_we`=1, also mem[`mem_addr`] <= `mem_data`.
  - Read-during-write to the same address is read-first: `mem_in` shows the old word, and the new word is visible on the following read.
  - RUN is terminal until `rst_n`.
- `mem_in` is held at 0 outside RUN.
- Asserting `rst_n` in any state, including mid-CLEAR or mid-LOAD, returns every output to its reset value immediately and restarts at CLEAR. Partially loaded contents are re-zeroed.

## Timing
- CLEAR lasts exactly 2^ADDR_WIDTH cycles after `rst_n` deassertion: 64 for the defaults. `load_ready` rises on cycle 65.
- Load handshake: one word per cycle maximum. `load_ready` is a state decode with no combinational dependence on `load_valid`.
- Word with `load_last` accepted at edge N:
  - `load_ready`=0 after edge N.
  - `cpu_rst_n`=1 after edge N+1.
- Read latency is 1 cycle: address presented in cycle k gives data on `mem_in` in cycle k+1. This matches the CPU's address-then-consume state pairs.
- Write takes effect at the edge where `mem_we`=1.
- `load_count` saturates at its final value in RUN.

## Test plan
- Reset then idle: at cycle 64 after release, `load_ready`=0 and `cpu_rst_n`=0; at cycle 65, `load_ready`=1. A RUN read of address 0 and address 63 returns 0.
- Load 3 words 0x1111, 0x2222, 0x3333 (last on third), with one `load_valid` bubble inserted:
  - mem[8..10] holds them and `load_count`=3.
  - `cpu_rst_n` rises 1 cycle after the last word.
  - Reading address 9 gives 0x2222 the next cycle.
- RUN write then read: `mem_we`=1, addr 20, data 0xBEEF, then read addr 20 → `mem_in`=0xBEEF one cycle later.
- Read-during-write: addr 9 holds 0x2222; write 0xAAAA to addr 9 with same-cycle read → `mem_in`=0x2222, then 0xAAAA on the next read.
- Overflow: stream 56 words without `load_last` → word 56 lands at address 63, `load_ovf`=1, state RUN, and `load_count`=56.
- Reset mid-LOAD: load 2 words, pulse `rst_n` low for 1 cycle → `cpu_rst_n`=0 and `load_count`=0 immediately. After a new 64-cycle CLEAR, mem[8] reads 0.

Source files
------------

// File: rtl/cpu_memory_if.sv
// cpu_memory_if
//   Bundles the CPU memory bus, the boot-image load port and the boot
//   status lines that connect cpu_memory to the CPU and the board loader.
//   master : CPU/loader side (drives address, write data and load words).
//   slave  : memory side (drives read data, load_ready and boot status).
//   Signals:
//     mem_addr, mem_we, mem_data  CPU address / write enable / write data
//     mem_in                      registered read data to the CPU
//     load_valid/data/last/ready  load-port handshake
//     cpu_rst_n                   active-low reset released to the CPU
//     load_ovf                    sticky: image hit top of memory without last
//     load_count                  words accepted in the current load
interface cpu_memory_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;

    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;

    logic                  cpu_rst_n;
    logic                  load_ovf;
    logic [ADDR_WIDTH:0]   load_count;

    modport master (
        output mem_addr, mem_we, mem_data,
        output load_valid, load_data, load_last,
        input  mem_in, load_ready, cpu_rst_n, load_ovf, load_count
    );

    modport slave (
        input  mem_addr, mem_we, mem_data,
        input  load_valid, load_data, load_last,
        output mem_in, load_ready, cpu_rst_n, load_ovf, load_count
    );
endinterface

// File: rtl/cpu_memory.sv
// cpu_memory
//   Unified program/data memory with boot sequencing. After reset it zeroes
//   every word (CLEAR), accepts a program image starting at LOAD_BASE over a
//   valid/ready port (LOAD), then releases the CPU from reset and serves its
//   reads and writes (RUN) until the next rst_n.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    cpu_memory_if.slave: CPU bus, load port and boot status
module cpu_memory #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOAD_BASE  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_memory_if.slave   bus
);
    localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q,    clr_ptr_d;
    logic [ADDR_WIDTH-1:0] load_ptr_q,   load_ptr_d;
    logic [DATA_WIDTH-1:0] mem_in_q,     mem_in_d;
    logic                  load_ready_q, load_ready_d;
    logic                  cpu_rst_n_q,  cpu_rst_n_d;
    logic                  load_ovf_q,   load_ovf_d;
    logic [ADDR_WIDTH:0]   load_count_q, load_count_d;

    // Storage is deliberately not reset; CLEAR zeroes it word by word.
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    // Single shared write port, steered by state.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  load_accept;

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        load_ptr_d   = load_ptr_q;
        load_ovf_d   = load_ovf_q;
        load_count_d = load_count_q;
        mem_in_d     = '0;
        wr_en        = 1'b0;
        wr_addr      = bus.mem_addr;
        wr_data      = bus.mem_data;
        load_accept  = (state_q == ST_LOAD) && load_ready_q && bus.load_valid;

        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_ptr_q;
                wr_data   = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == TOP_ADDR) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (load_accept) begin
                    wr_en        = 1'b1;
                    wr_addr      = load_ptr_q;
                    wr_data      = bus.load_data;
                    load_count_d = load_count_q + 1'b1;
                    // Pointer stops at the top word so it can never wrap to 0.
                    if (load_ptr_q != TOP_ADDR) begin
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                    if (bus.load_last) begin
                        state_d = ST_RUN;
                    end else if (load_ptr_q == TOP_ADDR) begin
                        load_ovf_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Read-first: the old word is captured while the write lands.
                mem_in_d = mem_q[bus.mem_addr];
                wr_en    = bus.mem_we;
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Registered decodes: ready follows the next state so it is high on
        // the first LOAD cycle; the CPU reset releases one cycle into RUN.
        load_ready_d = (state_d == ST_LOAD);
        cpu_rst_n_d  = (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            load_ptr_q   <= BASE_ADDR;
            mem_in_q     <= '0;
            load_ready_q <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            load_ovf_q   <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            load_ptr_q   <= load_ptr_d;
            mem_in_q     <= mem_in_d;
            load_ready_q <= load_ready_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            load_ovf_q   <= load_ovf_d;
            load_count_q <= load_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus.mem_in     = mem_in_q;
    assign bus.load_ready = load_ready_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.load_ovf   = load_ovf_q;
    assign bus.load_count = load_count_q;
endmodule

// File: tb/tb_cpu_memory.sv
// tb_cpu_memory
//   Directed-vector bench for cpu_memory: boot timing, image load with a
//   bubble, RUN reads/writes, read-during-write, overflow and mid-load reset.
module tb_cpu_memory;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 16;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_miss;

    cpu_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cpu_memory #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LOAD_BASE (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_addr   = '0;
        bus.mem_we     = 1'b0;
        bus.mem_data   = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
    endtask

    // Reset pulse released on a falling edge, then the full 64-cycle CLEAR.
    task automatic reset_and_clear();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (63) tick();
        check("clear_ready_c64", bus.load_ready, 0);
        check("clear_cpurst_c64", bus.cpu_rst_n, 0);
        tick();
        check("clear_ready_c65", bus.load_ready, 1);
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
        bus.mem_addr = a;
        bus.mem_we   = 1'b0;
        tick();
        check(tag, bus.mem_in, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        bus.mem_addr = a;
        bus.mem_we   = 1'b1;
        bus.mem_data = d;
        tick();
        bus.mem_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        idle_inputs();
        #1;
        check("rst_ready", bus.load_ready, 0);
        check("rst_cpurst", bus.cpu_rst_n, 0);
        check("rst_count", bus.load_count, 0);
        check("rst_ovf", bus.load_ovf, 0);
        check("rst_memin", bus.mem_in, 0);

        // Boot and load three words with one bubble.
        reset_and_clear();
        push(16'h1111, 1'b0);
        tick();
        check("bubble_count", bus.load_count, 1);
        push(16'h2222, 1'b0);
        bus.mem_addr = 6'd9;
        check("load_memin_zero", bus.mem_in, 0);
        push(16'h3333, 1'b1);
        check("last_ready_drop", bus.load_ready, 0);
        check("last_cpurst_low", bus.cpu_rst_n, 0);
        check("load_count3", bus.load_count, 3);
        tick();
        check("cpurst_rise", bus.cpu_rst_n, 1);
        check("ovf_clear", bus.load_ovf, 0);

        rd("rd_a9", 6'd9, 16'h2222);
        rd("rd_a8", 6'd8, 16'h1111);
        rd("rd_a10", 6'd10, 16'h3333);
        rd("rd_a0", 6'd0, 16'h0000);
        rd("rd_a63", 6'd63, 16'h0000);
        rd("rd_a11", 6'd11, 16'h0000);

        // Load port ignored in RUN.
        push(16'h7777, 1'b1);
        check("run_ignore_count", bus.load_count, 3);
        check("run_ignore_ready", bus.load_ready, 0);
        rd("run_ignore_a11", 6'd11, 16'h0000);

        wr(6'd20, 16'hBEEF);
        rd("wr_rd_a20", 6'd20, 16'hBEEF);

        // Read-during-write returns the old word.
        bus.mem_addr = 6'd9;
        bus.mem_we   = 1'b1;
        bus.mem_data = 16'hAAAA;
        tick();
        check("rdw_old", bus.mem_in, 16'h2222);
        bus.mem_we = 1'b0;
        tick();
        check("rdw_new", bus.mem_in, 16'hAAAA);

        // Overflow: 56 words from address 8 up to 63 without last.
        idle_inputs();
        reset_and_clear();
        check("ovf_reclear_count", bus.load_count, 0);
        for (int i = 0; i < 55; i++) begin
            push(16'h0100 + 16'(i), 1'b0);
        end
        check("ovf_pre_flag", bus.load_ovf, 0);
        check("ovf_pre_ready", bus.load_ready, 1);
        push(16'h0137, 1'b0);
        check("ovf_flag", bus.load_ovf, 1);
        check("ovf_count", bus.load_count, 56);
        check("ovf_ready", bus.load_ready, 0);
        tick();
        check("ovf_cpurst", bus.cpu_rst_n, 1);
        rd("ovf_a63", 6'd63, 16'h0137);
        rd("ovf_a8", 6'd8, 16'h0100);
        rd("ovf_a0", 6'd0, 16'h0000);
        check("ovf_sticky", bus.load_ovf, 1);

        // Reset in the middle of a load.
        reset_and_clear();
        push(16'hA5A5, 1'b0);
        push(16'h5A5A, 1'b0);
        check("mid_count2", bus.load_count, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", bus.load_count, 0);
        check("mid_rst_cpurst", bus.cpu_rst_n, 0);
        check("mid_rst_ready", bus.load_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (64) tick();
        check("mid_ready_back", bus.load_ready, 1);
        push(16'h0777, 1'b1);
        tick();
        check("mid_cpurst", bus.cpu_rst_n, 1);
        rd("mid_a9_zeroed", 6'd9, 16'h0000);
        rd("mid_a8_new", 6'd8, 16'h0777);
        check("mid_count1", bus.load_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
